mac_acc_pipe: RTL and testbench
===============================

// Module: mac_acc_pipe
// PURPOSE
//  Pipelined, accumulating successor to the combinational 8-input MAC column.
//  Each accepted beat is the dot product of PR lanes (a_i*b_i). Beats accumulate into one psum until a beat tagged in_last.
//  The finished psum is then presented on a valid/ready output.
//  Sits between the L0 operand feeder and the psum/OFIFO stage of a MAC column; signed/unsigned mode is selected per beat.
// PARAMETERS
//  BW       8   operand width per lane
//  BW_PSUM  32  accumulator/output width; must be >= 2*BW+$clog2(PR)+1 (elaboration error otherwise)
//  PR       8   lanes per beat (power of 2, >= 2)
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-high
//  in_valid    in   1          beat present on a/b/in_last/mode_signed
//  in_ready    out  1          block accepts beat this cycle
//  a           in   PR*BW      lane operands, lane 0 = LSBs
//  b           in   PR*BW      lane operands, lane 0 = LSBs
//  mode_signed in   1          1: lanes two's complement; 0: unsigned
//  in_last     in   1          beat closes current accumulation
//  out_valid   out  1          psum available
//  out_ready   in   1          downstream takes psum
//  out_psum    out  BW_PSUM    accumulated result, two's complement
//  out_beats   out  16         beats in this psum (saturates at 16'hFFFF)
//  out_ovf     out  1          accumulation overflowed (see CONFIGURATION)
// BEHAVIOUR
//  Handshake: transfer on in_valid&&in_ready / out_valid&&out_ready. in_ready = !(out_valid && !out_ready).
//   When in_ready=0, all stages freeze (global stall); nothing is dropped or duplicated.
//  Pipeline (each stage has a valid bit):
//   S1 registers PR products; 2*BW bits each, sign- or zero-extended per mode_signed.
//   S2 registers the adder-tree sum, extended to BW_PSUM.
//   S3 updates the accumulator: acc <= (first ? 0 : acc) + sum.
//  Latency: in_last beat accepted at cycle t -> out_valid=1 at t+3. Back-to-back beats every cycle, no bubbles.
//  FSM on S3: ACC_IDLE (first=1) -S3 beat, !last-> ACC_RUN; any state -S3 beat+last-> ACC_HOLD.
//   ACC_HOLD -out_ready-> ACC_IDLE. In ACC_IDLE/ACC_RUN a bubble (no S3 valid) holds state.
//  out_psum/out_beats/out_ovf are stable while out_valid && !out_ready.
//   The next accumulation starts with the S3 beat that enters on the out_ready cycle.
//  Single-beat accumulation (in_last on the first beat) is legal: out_beats=1.
//  Unsigned and signed beats may be mixed within one accumulation. Each sum is extended per its own mode.
//  Reset values: in_ready=1 after reset deasserts, out_valid=0, out_psum=0, out_beats=0, out_ovf=0.
//   Reset also clears all stage valids and the FSM state (ACC_IDLE).
//  Reset mid-operation: partial accumulation and in-flight beats are discarded, no output is produced.
// CONFIGURATION
//  MAC_SAT_EN defined: signed overflow on acc add clamps acc to 2^(BW_PSUM-1)-1 or -2^(BW_PSUM-1).
//   out_ovf goes sticky-1 for that psum. Later beats keep accumulating from the clamped value.
//  MAC_SAT_EN undefined: acc wraps modulo 2^BW_PSUM; out_ovf tied 0; no saturation logic.
// STRUCTURE
//  Package mac_pkg:
//   - default BW/BW_PSUM/PR constants
//   - acc_state_t enum {ACC_IDLE, ACC_RUN, ACC_HOLD}
//   - function psum_min_w(bw,pr)
//  Sub-module mac_prod_tree: products + balanced adder tree.
//   Combinational, parameterised by BW/PR/mode. The top instantiates it and places the S1/S2 registers around it.
// TESTING
//  1. a=b={8'd1..8'd8} (lane 0=8), mode_signed=0, in_last=1 -> out_valid at t+3, out_psum=204, out_beats=1.
//  2. Same vector for 3 consecutive beats, last on the 3rd -> single output out_psum=612, out_beats=3.
//  3. All a lanes 8'hFF, all b lanes 8'd2, last=1: mode_signed=1 -> out_psum=-16; mode_signed=0 -> 4080.
//  4. Test 1 with out_ready=0 for 5 cycles after out_valid -> in_ready=0 and psum held at 204.
//     Queued beats are emitted in order after release.
//  5. BW_PSUM=20, a=b=all 255, unsigned, 2 beats:
//     MAC_SAT_EN -> out_psum=524287, out_ovf=1; without -> raw 20'd1040400 (-8176), out_ovf=0.
//  6. Assert reset for 1 cycle after the 2nd beat of a 3-beat run -> no output.
//     Next single beat of test 1 -> 204, out_beats=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants, accumulator FSM type and width helper for the accumulating MAC column.
package mac_pkg;

  localparam int unsigned DefBw     = 8;
  localparam int unsigned DefBwPsum = 32;
  localparam int unsigned DefPr     = 8;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RUN  = 2'd1,
    ACC_HOLD = 2'd2
  } acc_state_t;

  // Narrowest psum that holds a full signed or unsigned beat sum plus a sign bit.
  function automatic int unsigned psum_min_w(input int unsigned bw, input int unsigned pr);
    return 2 * bw + $clog2(pr) + 1;
  endfunction

endpackage

// File: rtl/mac_prod_tree.sv
// Per-lane products and a balanced adder tree; purely combinational, the caller
// registers between the product and sum halves.
module mac_prod_tree
  import mac_pkg::*;
#(
  parameter int unsigned BW      = DefBw,
  parameter int unsigned BW_PSUM = DefBwPsum,
  parameter int unsigned PR      = DefPr
) (
  input  logic [PR*BW-1:0]   a_i,
  input  logic [PR*BW-1:0]   b_i,
  input  logic               mode_signed_i,
  output logic [PR*2*BW-1:0] prod_o,
  input  logic [PR*2*BW-1:0] prod_i,
  input  logic               prod_signed_i,
  output logic [BW_PSUM-1:0] sum_o
);

  localparam int unsigned ProdW = 2 * BW;
  localparam int unsigned SumW  = psum_min_w(BW, PR);
  localparam int unsigned Nodes = 2 * PR - 1;

  // Extending both operands to ProdW makes the truncated product exact in either mode.
  for (genvar i = 0; i < PR; i++) begin : g_lane
    logic [BW-1:0]    a_l;
    logic [BW-1:0]    b_l;
    logic [ProdW-1:0] a_x;
    logic [ProdW-1:0] b_x;

    assign a_l = a_i[i*BW +: BW];
    assign b_l = b_i[i*BW +: BW];
    assign a_x = {{BW{mode_signed_i & a_l[BW-1]}}, a_l};
    assign b_x = {{BW{mode_signed_i & b_l[BW-1]}}, b_l};
    assign prod_o[i*ProdW +: ProdW] = a_x * b_x;
  end

  // Heap-ordered tree: leaves at [PR-1 .. 2*PR-2], root at [0].
  logic [SumW-1:0] node [Nodes];

  always_comb begin
    for (int n = 0; n < Nodes; n++) begin
      node[n] = '0;
    end
    for (int i = 0; i < PR; i++) begin
      node[PR-1+i] = {{(SumW-ProdW){prod_signed_i & prod_i[i*ProdW+ProdW-1]}},
                      prod_i[i*ProdW +: ProdW]};
    end
    for (int n = PR - 2; n >= 0; n--) begin
      node[n] = node[2*n+1] + node[2*n+2];
    end
  end

  assign sum_o = BW_PSUM'($signed(node[0]));

endmodule

// File: rtl/mac_acc_pipe.sv
// Three-stage pipelined dot-product accumulator with valid/ready on both sides.
// Define MAC_SAT_EN to clamp signed accumulator overflow and report it on out_ovf_o.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int unsigned BW      = DefBw,
  parameter int unsigned BW_PSUM = DefBwPsum,
  parameter int unsigned PR      = DefPr
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PR*BW-1:0]   a_i,
  input  logic [PR*BW-1:0]   b_i,
  input  logic               mode_signed_i,
  input  logic               in_last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BW_PSUM-1:0] out_psum_o,
  output logic [15:0]        out_beats_o,
  output logic               out_ovf_o
);

  localparam int unsigned ProdBits = PR * 2 * BW;
  localparam int unsigned Msb      = BW_PSUM - 1;

  if (BW_PSUM < psum_min_w(BW, PR)) begin : g_bad_psum_w
    $error("mac_acc_pipe: BW_PSUM narrower than 2*BW+clog2(PR)+1");
  end
  if ((PR < 2) || ((PR & (PR - 1)) != 0)) begin : g_bad_pr
    $error("mac_acc_pipe: PR must be a power of two and at least 2");
  end

  logic advance;

  logic [ProdBits-1:0] prod_d;
  logic [ProdBits-1:0] s1_prod_q;
  logic                s1_valid_q;
  logic                s1_signed_q;
  logic                s1_last_q;

  logic [BW_PSUM-1:0]  sum_d;
  logic [BW_PSUM-1:0]  s2_sum_q;
  logic                s2_valid_q;
  logic                s2_last_q;

  acc_state_t          state_q, state_d;
  logic [BW_PSUM-1:0]  acc_q, acc_d;
  logic [15:0]         beats_q, beats_d;
  logic                out_valid_q;
  logic                first;
  logic [BW_PSUM-1:0]  base;
  logic [BW_PSUM-1:0]  acc_sum;

  // A held result with no taker freezes every stage at once.
  assign advance    = !(out_valid_q && !out_ready_i);
  assign in_ready_o = advance;

  mac_prod_tree #(
    .BW      (BW),
    .BW_PSUM (BW_PSUM),
    .PR      (PR)
  ) u_tree (
    .a_i           (a_i),
    .b_i           (b_i),
    .mode_signed_i (mode_signed_i),
    .prod_o        (prod_d),
    .prod_i        (s1_prod_q),
    .prod_signed_i (s1_signed_q),
    .sum_o         (sum_d)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_signed_q <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_last_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= in_valid_i;
      s1_prod_q   <= prod_d;
      s1_signed_q <= mode_signed_i;
      s1_last_q   <= in_last_i;
      s2_valid_q  <= s1_valid_q;
      s2_sum_q    <= sum_d;
      s2_last_q   <= s1_last_q;
    end
  end

  // Leaving ACC_RUN means the next S3 beat opens a fresh accumulation, including
  // the beat that arrives on the same edge the held result is taken.
  assign first = (state_q != ACC_RUN);
  assign base  = first ? '0 : acc_q;

`ifdef MAC_SAT_EN
  logic [BW_PSUM-1:0] raw_sum;
  logic               add_ovf;
  logic               ovf_q, ovf_d;

  assign raw_sum = base + s2_sum_q;
  assign add_ovf = (base[Msb] == s2_sum_q[Msb]) && (raw_sum[Msb] != base[Msb]);
  assign acc_sum = !add_ovf  ? raw_sum :
                   base[Msb] ? {1'b1, {Msb{1'b0}}} : {1'b0, {Msb{1'b1}}};
  assign out_ovf_o = ovf_q;
`else
  assign acc_sum   = base + s2_sum_q;
  assign out_ovf_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beats_d = beats_q;
`ifdef MAC_SAT_EN
    ovf_d   = ovf_q;
`endif
    if (s2_valid_q) begin
      acc_d   = acc_sum;
      beats_d = first ? 16'd1 : ((beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1);
`ifdef MAC_SAT_EN
      ovf_d   = add_ovf | (!first & ovf_q);
`endif
      state_d = s2_last_q ? ACC_HOLD : ACC_RUN;
    end else if (state_q == ACC_HOLD) begin
      state_d = ACC_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ACC_IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef MAC_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else if (advance) begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      out_valid_q <= (state_d == ACC_HOLD);
`ifdef MAC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_psum_o  = acc_q;
  assign out_beats_o = beats_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Self-checking bench: directed cases with literal results plus random traffic
// compared every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mac_acc_pipe;

  localparam int unsigned BW  = 8;
  localparam int unsigned PR  = 8;
  localparam int unsigned PW  = 32;
  localparam int unsigned PW2 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             in_valid = 1'b0, mode_signed = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [PR*BW-1:0] a = '0, b = '0;
  logic             in_ready, out_valid, out_ovf;
  logic [PW-1:0]    out_psum;
  logic [15:0]      out_beats;

  logic             in_valid2 = 1'b0, mode_signed2 = 1'b0, in_last2 = 1'b0, out_ready2 = 1'b1;
  logic [PR*BW-1:0] a2 = '0, b2 = '0;
  logic             in_ready2, out_valid2, out_ovf2;
  logic [PW2-1:0]   out_psum2;
  logic [15:0]      out_beats2;

  mac_acc_pipe #(.BW(BW), .BW_PSUM(PW), .PR(PR)) u_dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .mode_signed_i(mode_signed), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_psum_o(out_psum),
    .out_beats_o(out_beats), .out_ovf_o(out_ovf)
  );

  mac_acc_pipe #(.BW(BW), .BW_PSUM(PW2), .PR(PR)) u_dut20 (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .a_i(a2), .b_i(b2), .mode_signed_i(mode_signed2), .in_last_i(in_last2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .out_psum_o(out_psum2),
    .out_beats_o(out_beats2), .out_ovf_o(out_ovf2)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint psum;
    int     beats;
    bit     ovf;
  } res_t;

  res_t   expq[$];
  longint m_acc = 0;
  longint m_dot;
  int     m_beats = 0;
  bit     m_ovf = 1'b0;
  bit     m_first = 1'b1;
  bit     m_o;

  function automatic longint dot(input logic [PR*BW-1:0] x, input logic [PR*BW-1:0] y,
                                 input bit sgn);
    longint       s;
    logic [BW-1:0] xl, yl;
    s = 0;
    for (int i = 0; i < PR; i++) begin
      xl = x[i*BW +: BW];
      yl = y[i*BW +: BW];
      if (sgn) s += longint'($signed(xl)) * longint'($signed(yl));
      else     s += longint'(xl) * longint'(yl);
    end
    return s;
  endfunction

  // Bring an exact sum back into the w-bit signed range: clamp or wrap.
  function automatic longint fold(input longint v, input int w, output bit o);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    o  = 1'b0;
`ifdef MAC_SAT_EN
    if (v > mx) begin v = mx; o = 1'b1; end
    if (v < mn) begin v = mn; o = 1'b1; end
`else
    v = v & ((longint'(1) << w) - 1);
    if (v > mx) v -= (longint'(1) << w);
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      m_first = 1'b1;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          chk("model_psum", $signed(out_psum), expq[0].psum);
          chk("model_beats", out_beats, expq[0].beats);
          chk("model_ovf", out_ovf, expq[0].ovf);
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (m_first) begin
          m_acc = 0; m_beats = 0; m_ovf = 1'b0;
        end
        m_dot   = dot(a, b, mode_signed);
        m_acc   = fold(m_acc + m_dot, PW, m_o);
        m_ovf   = m_ovf | m_o;
        m_beats = (m_beats == 65535) ? m_beats : m_beats + 1;
        m_first = in_last;
        if (in_last) expq.push_back('{m_acc, m_beats, m_ovf});
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [PR*BW-1:0] v18 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  logic [PR*BW-1:0] vff = {8{8'hFF}};
  logic [PR*BW-1:0] v2  = {8{8'd2}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [PR*BW-1:0] x, input logic [PR*BW-1:0] y,
                       input bit sgn, input bit last);
    in_valid = 1'b1; a = x; b = y; mode_signed = sgn; in_last = last;
  endtask

  // Beat already driven; counts cycles from its acceptance until out_valid.
  task automatic wait_out(input string name, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int lat;
    int seen;

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psum", out_psum, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_out_ovf", out_ovf, 0);

    // Single unsigned beat.
    drive(v18, v18, 0, 1);
    wait_out("t1", 3);
    chk("t1_psum", $signed(out_psum), 204);
    chk("t1_beats", out_beats, 1);
    tick();
    chk("t1_out_valid_drop", out_valid, 0);

    // Three beats, last on the third.
    drive(v18, v18, 0, 0);
    tick();
    tick();
    drive(v18, v18, 0, 1);
    wait_out("t2", 3);
    chk("t2_psum", $signed(out_psum), 612);
    chk("t2_beats", out_beats, 3);
    tick();

    // Same bits, signed vs unsigned.
    drive(vff, v2, 1, 1);
    wait_out("t3s", 3);
    chk("t3_signed_psum", $signed(out_psum), -16);
    tick();
    drive(vff, v2, 0, 1);
    wait_out("t3u", 3);
    chk("t3_unsigned_psum", $signed(out_psum), 4080);
    tick();

    // Backpressure: three results queue behind a held one, a fourth beat waits.
    out_ready = 1'b0;
    drive(v18, v18, 0, 1);
    tick();
    drive(vff, v2, 1, 1);
    tick();
    drive(vff, v2, 0, 1);
    tick();
    drive(v18, v18, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_in_ready", in_ready, 0);
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_psum", $signed(out_psum), 204);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t4_second_valid", out_valid, 1);
    chk("t4_second_psum", $signed(out_psum), -16);
    tick();
    chk("t4_third_psum", $signed(out_psum), 4080);
    tick();
    chk("t4_fourth_psum", $signed(out_psum), 204);
    tick();
    chk("t4_drained", out_valid, 0);

    // Narrow accumulator overflow on the 20-bit instance.
    in_valid2 = 1'b1; a2 = vff; b2 = vff; mode_signed2 = 1'b0; in_last2 = 1'b0;
    tick();
    in_last2 = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) in_valid2 = 1'b0;
    end while (!out_valid2 && lat < 20);
    chk("t5_latency", lat, 3);
    chk("t5_beats", out_beats2, 2);
`ifdef MAC_SAT_EN
    chk("t5_psum", out_psum2, 524287);
    chk("t5_ovf", out_ovf2, 1);
`else
    chk("t5_psum", out_psum2, 1040400);
    chk("t5_ovf", out_ovf2, 0);
`endif
    tick();

    // Reset mid-accumulation discards everything.
    drive(v18, v18, 0, 0);
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("t6_no_output_after_reset", seen, 0);
    drive(v18, v18, 0, 1);
    wait_out("t6", 3);
    chk("t6_psum", $signed(out_psum), 204);
    chk("t6_beats", out_beats, 1);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      a           = {$urandom, $urandom};
      b           = {$urandom, $urandom};
      mode_signed = $urandom_range(0, 1);
      in_last     = ($urandom_range(0, 3) == 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      reset       = (c == 400);
      tick();
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    chk("drain_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
